// File: rtl/fc_argmax_seq.sv
// Sequential argmax over a latched signed vector, one compare per clock.
// Latency: OUT_SIZE-1 edges from start to done; no backpressure, start ignored while busy.
module fc_argmax_seq #(
  parameter int OUT_SIZE = 8,
  parameter int W        = 8,
  parameter int IDX_W    = $clog2(OUT_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W*OUT_SIZE-1:0]   in_vector_flat,
  output logic [IDX_W-1:0]        class_idx,
  output logic signed [W-1:0]     max_value,
  output logic                    all_negative,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(OUT_SIZE - 1);

  state_t                  state_q, state_d;
  logic signed [W-1:0]     vec_q [OUT_SIZE];
  logic signed [W-1:0]     vec_d [OUT_SIZE];
  logic signed [W-1:0]     best_val_q, best_val_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic [IDX_W-1:0]        class_idx_q, class_idx_d;
  logic signed [W-1:0]     max_value_q, max_value_d;
  logic                    all_neg_q, all_neg_d;

  logic signed [W-1:0]     elem;
  logic                    elem_gt;
  logic signed [W-1:0]     scan_val;
  logic [IDX_W-1:0]        scan_idx;

  // Strict greater-than keeps the lowest index on ties.
  assign elem     = vec_q[k_q];
  assign elem_gt  = elem > best_val_q;
  assign scan_val = elem_gt ? elem : best_val_q;
  assign scan_idx = elem_gt ? k_q : best_idx_q;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    k_d         = k_q;
    class_idx_d = class_idx_q;
    max_value_d = max_value_q;
    all_neg_d   = all_neg_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int i = 0; i < OUT_SIZE; i++) begin
            vec_d[i] = in_vector_flat[i*W +: W];
          end
          best_val_d = in_vector_flat[W-1:0];
          best_idx_d = '0;
          k_d        = IDX_W'(1);
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        best_val_d = scan_val;
        best_idx_d = scan_idx;
        k_d        = k_q + IDX_W'(1);
        // The last compare publishes its own result, not the stale best.
        if (k_q == LAST_K) begin
          class_idx_d = scan_idx;
          max_value_d = scan_val;
          all_neg_d   = scan_val[W-1];
          state_d     = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      k_q         <= '0;
      class_idx_q <= '0;
      max_value_q <= '0;
      all_neg_q   <= 1'b0;
      for (int i = 0; i < OUT_SIZE; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      k_q         <= k_d;
      class_idx_q <= class_idx_d;
      max_value_q <= max_value_d;
      all_neg_q   <= all_neg_d;
      for (int i = 0; i < OUT_SIZE; i++) begin
        vec_q[i] <= vec_d[i];
      end
    end
  end

  assign class_idx    = class_idx_q;
  assign max_value    = max_value_q;
  assign all_negative = all_neg_q;
  assign busy         = (state_q == ST_SCAN);
  assign done         = (state_q == ST_DONE);

endmodule

// File: doc/fc_argmax_seq.md
# fc_argmax_seq

Sequential argmax stage that sits directly downstream of the first fully connected layer. On a `start` pulse, it captures the flattened signed output vector and scans it one element per clock. It then reports the index and value of the largest neuron, plus a done pulse. `start` is driven by the FC layer's `done`, and `in_vector_flat` by its `out_vector_flat`, so this block produces the network's class decision.

## Interface
Parameters:
- `OUT_SIZE`, 8, number of neurons in the input vector (must be ≥ 2).
- `W`, 8, bit width of each signed element.
- `IDX_W`, `$clog2(OUT_SIZE)` (3), width of the class index.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  single-cycle capture request; connected to the FC layer `done`.
- `in_vector_flat`  in  W*OUT_SIZE  signed elements; element k occupies `[k*W +: W]`.
- `class_idx`  out  IDX_W  index of the maximum element.
- `max_value`  out  W  signed value of the maximum element.
- `all_negative`  out  1  high when `max_value` < 0.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when the outputs update.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SCAN: comparing one element per cycle.
  - DONE: one cycle, `done` asserted.
- IDLE/DONE → SCAN when `start`=1. On that edge:
  - latch the full `in_vector_flat` into an internal register;
  - set best_val = element 0, best_idx = 0, counter k = 1.
- SCAN, each edge:
  - compare latched element k against best_val as signed W-bit values;
  - replace best_val/best_idx only if strictly greater, so ties resolve to the lowest index;
  - k increments.
- SCAN after element OUT_SIZE-1 is compared → DONE. On that edge:
  - `class_idx` ← best_idx, `max_value` ← best_val, `all_negative` ← best_val[W-1];
  - `done` ← 1.
- DONE with no `start` → IDLE. `start` in the DONE cycle is accepted, allowing back-to-back vectors with no gap.
- `start` while in SCAN is ignored; the in-flight scan is not disturbed.
- The input vector is sampled only on the accepting edge. Later changes to `in_vector_flat` have no effect.
- Outputs `class_idx`, `max_value` and `all_negative` change only on the edge that enters DONE, and hold until the next completion or reset.
- Reset (any state, including mid-SCAN):
  - state → IDLE;
  - `class_idx`=0, `max_value`=0, `all_negative`=0, `busy`=0, `done`=0;
  - internal registers cleared;
  - an aborted scan never produces `done`.
  - Reset has priority over a simultaneous `start`.

## Timing
- Edge E0 samples `start`=1; `busy`=1 from E0.
- Edges E1..E(OUT_SIZE-1) perform the comparisons.
- Edge E(OUT_SIZE-1) also enters DONE: `done`=1 and outputs are valid in the cycle following it.
- Latency from the `start`-sampling edge to `done` high is OUT_SIZE-1 edges (7 for defaults).
- `busy` drops on the edge entering DONE.
- `done` is high for exactly one cycle unless a new `start` in DONE re-arms the block. The next `done` then arrives OUT_SIZE-1 edges later.
- Throughput: one vector per OUT_SIZE-1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset behaviour: hold `reset`=1 for 2 cycles → all outputs 0 and `busy`=0.
  - Then vector {-12,-8,-4,0,4,8,12,16} (element 0 first) with `start` pulse → `done` 7 edges later, `class_idx`=7, `max_value`=16, `all_negative`=0.
- Tie-breaking: all elements 5 → `class_idx`=0, `max_value`=5.
  - {3,9,9,1,9,0,0,0} → `class_idx`=1.
- Signed extremes:
  - {-3,-1,-1,-7,-128,-2,-5,-9} → `class_idx`=1, `max_value`=-1, `all_negative`=1.
  - {-128 everywhere except element 3 = 127} → `class_idx`=3, `max_value`=127.
- Input and start isolation: change `in_vector_flat` and pulse `start` during SCAN → result reflects the originally latched vector, and exactly one `done` is produced.
  - Back-to-back: a second `start` in the DONE cycle with a new vector → second `done` exactly 7 edges later with the new result.
- Reset mid-operation: assert `reset` at scan edge E3 → no `done`, outputs forced to 0, state IDLE.
  - A subsequent normal run completes correctly.
